boot_loader: RTL and testbench

BOOT_LOADER -- requirements
Module: boot_loader

---
 rtl/boot_loader.sv | 149 ++++++++++++++
 tb/tb_boot_loader.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/boot_loader.sv
// Serial program loader: receives a framed image (sync, length, payload, checksum),
// writes it into program memory, then releases the downstream CPU from reset.
module boot_loader (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [12:0] mem_addr,
  output logic [7:0]  mem_data,
  output logic        mem_wr,
  input  logic        cpu_halt,
  output logic        cpu_hold,
  output logic        done,
  output logic        err
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LEN_H = 3'd1,
    S_LEN_L = 3'd2,
    S_DATA  = 3'd3,
    S_CSUM  = 3'd4,
    S_RUN   = 3'd5,
    S_ERROR = 3'd6
  } state_t;

  localparam logic [7:0] SYNC = 8'hA5;

  state_t      state;
  logic [4:0]  len_hi;
  logic [12:0] length;
  logic [12:0] index;
  logic [7:0]  checksum;
  logic        accept;
  logic [12:0] frame_len;

  function automatic logic [7:0] csum_add(input logic [7:0] acc, input logic [7:0] b);
    return acc + b;
  endfunction

  assign accept    = in_valid & in_ready;
  assign frame_len = {len_hi, in_data};

  // Frame FSM with all outputs registered; in_ready tracks "next state is not RUN".
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= S_IDLE;
      in_ready <= 1'b1;
      mem_addr <= 13'd0;
      mem_data <= 8'd0;
      mem_wr   <= 1'b0;
      cpu_hold <= 1'b1;
      done     <= 1'b0;
      err      <= 1'b0;
      len_hi   <= 5'd0;
      length   <= 13'd0;
      index    <= 13'd0;
      checksum <= 8'd0;
    end else begin
      mem_wr <= 1'b0;
      case (state)
        S_IDLE: begin
          if (accept && (in_data == SYNC)) begin
            state <= S_LEN_H;
          end else begin
            state <= S_IDLE;
          end
        end
        S_LEN_H: begin
          if (accept) begin
            if (in_data[7:5] != 3'd0) begin
              state <= S_ERROR;
              err   <= 1'b1;
            end else begin
              len_hi <= in_data[4:0];
              state  <= S_LEN_L;
            end
          end else begin
            state <= S_LEN_H;
          end
        end
        S_LEN_L: begin
          if (accept) begin
            length   <= frame_len;
            index    <= 13'd0;
            checksum <= 8'd0;
            state    <= (frame_len != 13'd0) ? S_DATA : S_CSUM;
          end else begin
            state <= S_LEN_L;
          end
        end
        S_DATA: begin
          if (accept) begin
            mem_wr   <= 1'b1;
            mem_addr <= index;
            mem_data <= in_data;
            checksum <= csum_add(checksum, in_data);
            index    <= index + 13'd1;
            state    <= (index == (length - 13'd1)) ? S_CSUM : S_DATA;
          end else begin
            state <= S_DATA;
          end
        end
        S_CSUM: begin
          if (accept) begin
            if (in_data == checksum) begin
              state    <= S_RUN;
              in_ready <= 1'b0;
              cpu_hold <= 1'b0;
              done     <= 1'b1;
            end else begin
              state <= S_ERROR;
              err   <= 1'b1;
            end
          end else begin
            state <= S_CSUM;
          end
        end
        S_RUN: begin
          if (cpu_halt) begin
            state    <= S_IDLE;
            in_ready <= 1'b1;
            cpu_hold <= 1'b1;
            done     <= 1'b0;
          end else begin
            state <= S_RUN;
          end
        end
        S_ERROR: begin
          if (accept && (in_data == SYNC)) begin
            state <= S_LEN_H;
            err   <= 1'b0;
          end else begin
            state <= S_ERROR;
          end
        end
        default: begin
          state    <= S_IDLE;
          in_ready <= 1'b1;
          cpu_hold <= 1'b1;
          done     <= 1'b0;
          err      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_boot_loader.sv
// Randomised and directed bench for boot_loader; expected writes and outcomes come from frame contents.
module tb_boot_loader;

  typedef logic [7:0] bq_t[$];

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  in_data = 8'd0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [12:0] mem_addr;
  logic [7:0]  mem_data;
  logic        mem_wr;
  logic        cpu_halt = 1'b0;
  logic        cpu_hold;
  logic        done;
  logic        err;

  int passed = 0;
  int total  = 0;
  int cyc    = 0;
  int last_acc = 0;
  logic [20:0] wq[$];
  int          wcyc[$];

  boot_loader dut (
    .clk(clk), .reset(reset),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .mem_addr(mem_addr), .mem_data(mem_data), .mem_wr(mem_wr),
    .cpu_halt(cpu_halt), .cpu_hold(cpu_hold), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Write monitor, sampled mid-cycle.
  always @(negedge clk) begin
    if (mem_wr === 1'b1) begin
      wq.push_back({mem_addr, mem_data});
      wcyc.push_back(cyc);
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  function automatic logic [7:0] sum8(input bq_t d);
    logic [7:0] s = 8'd0;
    foreach (d[i]) s = s + d[i];
    return s;
  endfunction

  task automatic send(input logic [7:0] b, input int max_gap);
    int t;
    repeat ($urandom_range(0, max_gap)) begin
      in_valid = 1'b0;
      in_data  = 8'($urandom);
      @(posedge clk); #1;
    end
    in_valid = 1'b1;
    in_data  = b;
    t = 0;
    while (in_ready !== 1'b1 && t < 50) begin
      @(posedge clk); #1;
      t++;
    end
    if (t >= 50) begin
      chk("ready_timeout", in_ready, 1);
    end else begin
      @(posedge clk); #1;
      last_acc = cyc;
    end
    in_valid = 1'b0;
  endtask

  task automatic run_frame(input bq_t data, input logic [7:0] cs, input int gap);
    int n;
    int bad_cnt;
    int accs[$];
    logic [20:0] exp[$];
    logic good;
    n    = data.size();
    good = (cs == sum8(data));
    wq.delete();
    wcyc.delete();
    send(8'hA5, gap);
    send({3'b000, 5'(n >> 8)}, gap);
    send(8'(n), gap);
    foreach (data[i]) begin
      send(data[i], gap);
      accs.push_back(last_acc);
      exp.push_back({13'(i), data[i]});
    end
    send(cs, gap);
    chk("wr_count", wq.size(), n);
    bad_cnt = 0;
    for (int i = 0; i < n && i < wq.size(); i++) begin
      if (wq[i] !== exp[i] || wcyc[i] != accs[i]) bad_cnt++;
    end
    chk("wr_content_timing", bad_cnt, 0);
    chk("done", done, good);
    chk("err", err, !good);
    chk("cpu_hold", cpu_hold, !good);
    chk("in_ready", in_ready, !good);
  endtask

  task automatic halt_cpu();
    cpu_halt = 1'b1;
    @(posedge clk); #1;
    cpu_halt = 1'b0;
    chk("halt_hold", cpu_hold, 1);
    chk("halt_done", done, 0);
    chk("halt_ready", in_ready, 1);
  endtask

  function automatic bq_t rand_data(input int n);
    bq_t q;
    for (int i = 0; i < n; i++) q.push_back(8'($urandom));
    return q;
  endfunction

  initial begin
    bq_t q;
    #1 reset = 1'b0;
    #11;
    chk("rst_ready", in_ready, 1);
    chk("rst_addr", mem_addr, 0);
    chk("rst_data", mem_data, 0);
    chk("rst_wr", mem_wr, 0);
    chk("rst_hold", cpu_hold, 1);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    @(negedge clk) reset = 1'b1;
    @(posedge clk); #1;

    q = '{8'h11, 8'h22, 8'h33};
    run_frame(q, 8'h66, 0);

    wq.delete();
    in_valid = 1'b1;
    in_data  = 8'hA5;
    repeat (3) @(posedge clk);
    #1 in_valid = 1'b0;
    chk("run_ignore_done", done, 1);
    chk("run_ignore_ready", in_ready, 0);
    chk("run_ignore_wr", wq.size(), 0);

    halt_cpu();
    q = rand_data(10);
    run_frame(q, sum8(q), 0);

    halt_cpu();
    q = '{8'h01, 8'h02};
    run_frame(q, 8'h04, 0);
    q = '{8'h07};
    run_frame(q, 8'h07, 0);

    halt_cpu();
    q = {};
    run_frame(q, 8'h00, 0);

    halt_cpu();
    wq.delete();
    send(8'hA5, 0);
    send(8'h20, 0);
    chk("badhdr_err", err, 1);
    chk("badhdr_done", done, 0);
    chk("badhdr_hold", cpu_hold, 1);
    chk("badhdr_wr", wq.size(), 0);

    q = rand_data(37);
    run_frame(q, sum8(q), 3);
    halt_cpu();
    q = rand_data(6);
    run_frame(q, sum8(q) ^ 8'h5A, 2);

    wq.delete();
    send(8'hA5, 0);
    send(8'h00, 0);
    send(8'h05, 0);
    send(8'h10, 0);
    send(8'h20, 0);
    @(posedge clk); #1;
    chk("pre_reset_wr", wq.size(), 2);
    wq.delete();
    #2 reset = 1'b0;
    #1;
    chk("async_addr", mem_addr, 0);
    chk("async_data", mem_data, 0);
    chk("async_wr", mem_wr, 0);
    chk("async_hold", cpu_hold, 1);
    chk("async_done", done, 0);
    chk("async_err", err, 0);
    chk("async_ready", in_ready, 1);
    @(posedge clk); #1;
    reset = 1'b1;
    send(8'h30, 0);
    send(8'h40, 0);
    send(8'h50, 0);
    send(8'hF0, 0);
    @(posedge clk); #1;
    chk("post_reset_wr", wq.size(), 0);
    chk("post_reset_done", done, 0);
    chk("post_reset_err", err, 0);

    q = rand_data(8191);
    run_frame(q, sum8(q), 0);
    chk("max_last_addr", (wq.size() > 0) ? 32'(wq[$][20:8]) : 32'h0, 32'h1FFE);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
